mbscore_mem_stage: RTL
======================

# mbscore_mem_stage

Memory-access stage of the MBScore pipeline, sitting directly downstream of the ALU/execute stage and upstream of write-back. It takes the ALU result as either a pass-through value or an effective address, runs byte/halfword/word loads and stores against a req/ack data-memory port, sign- or zero-extends load data, and presents one registered result per instruction to write-back. A three-state FSM stalls execute with a ready handshake while a memory transaction is outstanding.

## Interface
Parameters:
- none; data width is `DATA_WIDTH` (32), register index width is 5.

Ports:
- clk  in  1  Single clock; all state changes on the rising edge.
- rst_n  in  1  Reset, asynchronous, active-low.
- ex_valid  in  1  Execute stage presents an instruction.
- ex_ready  out  1  Stage can accept; equals (state == IDLE).
- ex_alu_out  in  32  ALU result: effective address for memory ops, result otherwise.
- ex_store_data  in  32  rs2 value for stores.
- ex_mem_op  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9–15 treated as NONE.
- ex_rd  in  5  Destination register.
- ex_reg_write  in  1  Instruction writes rd.
- dmem_req  out  1  Memory request; held until the ack cycle.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  Word address: {ex_alu_out[31:2], 2'b00}.
- dmem_be  out  4  Byte enables, little-endian lanes.
- dmem_wdata  out  32  Store data, replicated across lanes.
- dmem_ack  in  1  Transaction complete; load data valid this cycle.
- dmem_rdata  in  32  Load data.
- wb_valid  out  1  One-cycle pulse: result for write-back.
- wb_rd  out  5  Destination register.
- wb_reg_write  out  1  Write enable to the register file.
- wb_data  out  32  Result / extended load data.
- wb_misalign  out  1  Misaligned-access exception, qualified by wb_valid.

## Operation
- Accept occurs when ex_valid && ex_ready. All ex_* fields are latched on accept.
- FSM states:
  - IDLE
    - Accept of a NONE op or a misaligned op goes to DONE.
    - Accept of an aligned memory op goes to WAIT.
  - WAIT
    - dmem_req = 1.
    - On dmem_ack, latch dmem_rdata and go to DONE.
  - DONE
    - wb_valid = 1 for one cycle.
    - Always returns to IDLE.
- Byte lane k = addr[1:0] selects bits [8k+7:8k]. Halfword lane selects [15:0] if addr[1] = 0, else [31:16].
- Byte enables:
  - SB/LB/LBU: 4'b0001 << addr[1:0].
  - SH/LH/LHU: 4'b0011 << {addr[1], 1'b0}.
  - SW/LW: 4'b1111.
- Store data:
  - SB: dmem_wdata = {4{data[7:0]}}.
  - SH: {2{data[15:0]}}.
  - SW: data.
- Load extension:
  - LB and LH sign-extend the selected byte or halfword.
  - LBU and LHU zero-extend it.
  - LW passes the word through unchanged.
- Misalignment is LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] ≠ 0.
  - No dmem_req is issued.
  - In DONE: wb_misalign = 1, wb_reg_write = 0, wb_data = the faulting address.
- Stores always produce wb_reg_write = 0 and wb_data = address.
- NONE ops produce wb_data = ex_alu_out and wb_reg_write = ex_reg_write.
- dmem_we, dmem_addr, dmem_be and dmem_wdata are registered. They are stable for the whole WAIT period and are 0 outside WAIT.

## Timing
- Reset values:
  - State is IDLE.
  - ex_ready = 1.
  - Every other output, including all dmem_* and wb_* outputs, is 0.
- Reset mid-WAIT drops dmem_req immediately, with no wb_valid. The memory side must tolerate an abandoned request.
- NONE op accepted in cycle T: wb_valid in cycle T+1, ex_ready = 0 in T+1.
- Memory op accepted in T:
  - dmem_req = 1 from T+1 through the cycle where dmem_ack = 1, T+k (k ≥ 1). Same-cycle ack at T+1 is legal.
  - wb_valid in T+k+1.
  - ex_ready = 1 again in T+k+2.
- Throughput is one instruction per 2 cycles for NONE ops. There is no accept in the DONE cycle.
- dmem_ack outside WAIT is ignored.
- Write-back has no backpressure: the wb_valid pulse is never held.
- ex_valid while ex_ready = 0 is not consumed. Execute holds its fields until accepted.

## Test plan
- **Reset:** assert rst_n = 0 mid-WAIT → dmem_req falls without waiting for clk; all outputs are 0 and ex_ready = 1 after release.
- **Pass-through:** NONE op, alu_out = 0x1234_5678, rd = 7, reg_write = 1 → next cycle wb_valid = 1, wb_data = 0x1234_5678, wb_rd = 7, wb_reg_write = 1.
- **LB sign-extension:** LB at addr 0x103, rdata = 0x80AA_BBCC, ack after 3 WAIT cycles →
  - dmem_addr = 0x100, be = 4'b1000.
  - wb_data = 0xFFFF_FF80, one cycle after ack.
- **LHU zero-extension:** LHU at addr 0x102, rdata = 0x8001_0000 → be = 4'b1100, wb_data = 0x0000_8001.
- **SB and SW:**
  - SB at addr 0x21, store_data = 0xDEAD_BEEF → we = 1, be = 4'b0010, wdata = 0xEFEF_EFEF, wb_reg_write = 0.
  - SW at addr 0x40, ack same cycle as first req → wb_valid exactly 2 cycles after accept.
- **Misaligned access:** LW at addr 0x202 → no dmem_req ever; next cycle wb_valid = 1, wb_misalign = 1, wb_reg_write = 0, wb_data = 0x202.

Source files
------------

// File: rtl/mbscore_mem_stage.sv
// -----------------------------------------------------------------------------
// mbscore_mem_stage
//
// Memory-access stage of the MBScore pipeline. Sits between execute and
// write-back. The ALU result is either forwarded as the instruction result or
// used as the effective address of a byte/halfword/word load or store. Memory
// transactions run on a simple req/ack port; while one is outstanding the
// stage holds off execute through ex_ready. Every instruction produces exactly
// one registered write-back pulse.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   ex_valid          execute presents an instruction
//   ex_ready          stage can accept (high only in IDLE)
//   ex_alu_out        ALU result / effective address
//   ex_store_data     rs2 value for stores
//   ex_mem_op         0 NONE,1 LB,2 LH,3 LW,4 LBU,5 LHU,6 SB,7 SH,8 SW, 9-15 NONE
//   ex_rd             destination register index
//   ex_reg_write      instruction writes rd
//   dmem_req          memory request, held through the ack cycle
//   dmem_we           1 = store
//   dmem_addr         word-aligned address
//   dmem_be           little-endian byte enables
//   dmem_wdata        store data replicated across lanes
//   dmem_ack          transaction complete, load data valid this cycle
//   dmem_rdata        load data
//   wb_valid          one-cycle result pulse to write-back
//   wb_rd             destination register index
//   wb_reg_write      register-file write enable
//   wb_data           result or extended load data
//   wb_misalign       misaligned-access exception, qualified by wb_valid
// -----------------------------------------------------------------------------
module mbscore_mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    // execute side
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_store_data,
    input  logic [3:0]  ex_mem_op,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    // data memory port
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    // write-back side
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        wb_misalign
);

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LW   = 4'd3;
    localparam logic [3:0] OP_LBU  = 4'd4;
    localparam logic [3:0] OP_LHU  = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------
    function automatic logic is_load(input logic [3:0] op);
        logic r;
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: r = 1'b1;
            default:                             r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        logic r;
        case (op)
            OP_SB, OP_SH, OP_SW: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

    // Halfwords need an even address, words need a 4-byte aligned address.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lane);
        logic r;
        case (op)
            OP_LH, OP_LHU, OP_SH: r = lane[0];
            OP_LW, OP_SW:         r = (lane != 2'b00);
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [3:0] op, input logic [1:0] lane);
        logic [3:0] r;
        case (op)
            OP_LB, OP_LBU, OP_SB: r = 4'b0001 << lane;
            OP_LH, OP_LHU, OP_SH: r = 4'b0011 << {lane[1], 1'b0};
            OP_LW, OP_SW:         r = 4'b1111;
            default:              r = 4'b0000;
        endcase
        return r;
    endfunction

    // Replicating the store value lets the memory pick its lane purely from dmem_be.
    function automatic logic [31:0] store_lanes(input logic [3:0] op, input logic [31:0] data);
        logic [31:0] r;
        case (op)
            OP_SB:   r = {4{data[7:0]}};
            OP_SH:   r = {2{data[15:0]}};
            OP_SW:   r = data;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extend(input logic [3:0]  op,
                                                input logic [1:0]  lane,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            2'd3:    b = rdata[31:24];
            default: b = rdata[7:0];
        endcase
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'd0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'd0, h};
            OP_LW:   r = rdata;
            default: r = rdata;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q,        state_d;
    logic [3:0]  op_q,           op_d;
    logic [31:0] addr_q,         addr_d;
    logic [4:0]  rd_q,           rd_d;
    logic        reg_write_q,    reg_write_d;
    logic        dmem_we_q,      dmem_we_d;
    logic [31:0] dmem_addr_q,    dmem_addr_d;
    logic [3:0]  dmem_be_q,      dmem_be_d;
    logic [31:0] dmem_wdata_q,   dmem_wdata_d;
    logic [4:0]  wb_rd_q,        wb_rd_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic [31:0] wb_data_q,      wb_data_d;
    logic        wb_misalign_q,  wb_misalign_d;

    logic accept_s;
    logic mem_op_s;
    logic misalign_s;

    // Accept qualification and decode of the presented instruction.
    always_comb begin
        accept_s   = ex_valid && (state_q == ST_IDLE);
        mem_op_s   = is_load(ex_mem_op) || is_store(ex_mem_op);
        misalign_s = is_misaligned(ex_mem_op, ex_alu_out[1:0]);
    end

    // Next-state logic for the FSM, the latched instruction and all registered outputs.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        addr_d         = addr_q;
        rd_d           = rd_q;
        reg_write_d    = reg_write_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_be_d      = dmem_be_q;
        dmem_wdata_d   = dmem_wdata_q;
        wb_rd_d        = wb_rd_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_data_d      = wb_data_q;
        wb_misalign_d  = wb_misalign_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    op_d        = ex_mem_op;
                    addr_d      = ex_alu_out;
                    rd_d        = ex_rd;
                    reg_write_d = ex_reg_write;
                    if (mem_op_s && !misalign_s) begin
                        state_d      = ST_WAIT;
                        dmem_we_d    = is_store(ex_mem_op);
                        dmem_addr_d  = {ex_alu_out[31:2], 2'b00};
                        dmem_be_d    = byte_enable(ex_mem_op, ex_alu_out[1:0]);
                        dmem_wdata_d = store_lanes(ex_mem_op, ex_store_data);
                    end else begin
                        // NONE and misaligned ops both report ex_alu_out; a
                        // misaligned op reports it as the faulting address.
                        state_d        = ST_DONE;
                        wb_rd_d        = ex_rd;
                        wb_data_d      = ex_alu_out;
                        wb_misalign_d  = misalign_s;
                        wb_reg_write_d = misalign_s ? 1'b0 : ex_reg_write;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    state_d       = ST_DONE;
                    dmem_we_d     = 1'b0;
                    dmem_addr_d   = 32'd0;
                    dmem_be_d     = 4'd0;
                    dmem_wdata_d  = 32'd0;
                    wb_rd_d       = rd_q;
                    wb_misalign_d = 1'b0;
                    if (is_store(op_q)) begin
                        wb_reg_write_d = 1'b0;
                        wb_data_d      = addr_q;
                    end else begin
                        wb_reg_write_d = reg_write_q;
                        wb_data_d      = load_extend(op_q, addr_q[1:0], dmem_rdata);
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                // Write-back has no backpressure, so the result lives one cycle.
                state_d        = ST_IDLE;
                wb_rd_d        = 5'd0;
                wb_reg_write_d = 1'b0;
                wb_data_d      = 32'd0;
                wb_misalign_d  = 1'b0;
            end
            default: begin
                state_d        = ST_IDLE;
                dmem_we_d      = 1'b0;
                dmem_addr_d    = 32'd0;
                dmem_be_d      = 4'd0;
                dmem_wdata_d   = 32'd0;
                wb_rd_d        = 5'd0;
                wb_reg_write_d = 1'b0;
                wb_data_d      = 32'd0;
                wb_misalign_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_NONE;
            addr_q         <= 32'd0;
            rd_q           <= 5'd0;
            reg_write_q    <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= 32'd0;
            dmem_be_q      <= 4'd0;
            dmem_wdata_q   <= 32'd0;
            wb_rd_q        <= 5'd0;
            wb_reg_write_q <= 1'b0;
            wb_data_q      <= 32'd0;
            wb_misalign_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            rd_q           <= rd_d;
            reg_write_q    <= reg_write_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_be_q      <= dmem_be_d;
            dmem_wdata_q   <= dmem_wdata_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_data_q      <= wb_data_d;
            wb_misalign_q  <= wb_misalign_d;
        end
    end

    // Handshake signals are pure decodes of the state register, so reset
    // drops dmem_req immediately without waiting for a clock edge.
    assign ex_ready     = (state_q == ST_IDLE);
    assign dmem_req     = (state_q == ST_WAIT);
    assign wb_valid     = (state_q == ST_DONE);
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_be      = dmem_be_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_data      = wb_data_q;
    assign wb_misalign  = wb_misalign_q;

endmodule
